tick_seq_ctrl: RTL and testbench
================================

# tick_seq_ctrl

Command sequencer for the 64-bit tick counter. It sits between the tick register block and the tick counter, and turns single register-issued commands (start, stop, clear, timed window, snapshot) into cycle-exact `enable_ticks`/`reset_ticks` sequencing. It also captures atomic 64-bit snapshots of `data_tick`, so software reads a consistent high/low pair.

## Interface
Parameters:
- `CLEAR_CYCLES`, 2: number of cycles `reset_ticks` stays asserted per CLEAR (1..15).
- `WIN_WIDTH`, 32: width of the window length argument and its down-counter.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: controller can accept a command; transfer occurs when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op` in 3: opcode. 0 SNAP, 1 START, 2 STOP, 3 CLEAR, 4 WINDOW, 5–7 illegal.
- `cmd_arg` in `WIN_WIDTH`: window length in cycles, used by WINDOW only.
- `data_tick` in 64: current tick counter value.
- `enable_ticks` out 1: counter enable, registered.
- `reset_ticks` out 1: counter synchronous clear, registered.
- `snap_data` out 64: last captured tick value.
- `snap_valid` out 1: one-cycle pulse, `snap_data` updated this cycle.
- `window_done` out 1: one-cycle pulse, window expired normally.
- `cmd_err` out 1: one-cycle pulse, illegal opcode accepted.
- `state` out 2: FSM state for status readback (IDLE 0, RUN 1, WIN 2, CLR 3).

## Operation
- Reset (async) values: state IDLE, `enable_ticks` 0, `reset_ticks` 0, `snap_data` 0, `snap_valid` 0, `window_done` 0, `cmd_err` 0, window and clear counters 0.
- `cmd_ready` is high in IDLE, RUN and WIN, and low in CLR. It is combinational from state only.
- IDLE (`enable_ticks` 0):
  - START goes to RUN.
  - WINDOW with arg N>0 loads the counter with N and goes to WIN.
  - WINDOW with N=0 stays in IDLE and pulses `window_done` next cycle.
  - CLEAR goes to CLR.
  - STOP is a no-op.
- RUN (`enable_ticks` 1):
  - STOP goes to IDLE.
  - CLEAR goes to CLR; the counter is stopped during the clear.
  - START is a no-op.
  - WINDOW restarts as a window: loads N and goes to WIN (N=0 behaves as in IDLE and ends in IDLE).
- WIN (`enable_ticks` 1):
  - The counter decrements every cycle.
  - When the counter is at 1, the next state is IDLE. At that edge `enable_ticks` drops, `window_done` pulses, and `data_tick` is captured with a `snap_valid` pulse.
  - STOP aborts to IDLE with no `window_done`.
  - CLEAR aborts to CLR.
  - START is a no-op.
  - WINDOW reloads the counter with the new N.
- CLR (`enable_ticks` 0, `reset_ticks` 1):
  - Held for exactly `CLEAR_CYCLES` cycles, then return to IDLE.
  - Commands are not accepted during CLR.
- SNAP is legal in every accepting state and does not change state. It registers `data_tick` into `snap_data` and pulses `snap_valid`.
- Illegal opcode: the command is accepted, state is unchanged, and `cmd_err` pulses.
- SNAP accepted in the same cycle a window expires: one capture, one `snap_valid` pulse (not two).
- Window arithmetic: unsigned `WIN_WIDTH`; N = 2^WIN_WIDTH−1 is the maximum. The counter never wraps because it is only decremented while >1.

## Timing
- Command accepted at edge k: the state and `enable_ticks`/`reset_ticks` change at edge k (registered outputs are visible in cycle k+1).
- WINDOW N accepted at edge k: `enable_ticks` is high for exactly N cycles (edges k..k+N−1 to k+N). `window_done` and `snap_valid` are high in the cycle after edge k+N.
- `snap_data` holds the `data_tick` sampled at the capturing edge. Latency from SNAP acceptance to `snap_valid` is 1 cycle.
- CLEAR accepted at edge k: `reset_ticks` is high for cycles k+1..k+`CLEAR_CYCLES`, and `cmd_ready` returns high in the cycle after the last one.
- All pulse outputs last exactly one cycle.
- Asserting `reset` mid-window or mid-clear forces the reset values immediately with no `window_done`.

## Structure
- Shared package `tick_pkg`: the opcode constants (SNAP/START/STOP/CLEAR/WINDOW) and the 2-bit state encoding. This package is also used by the register block that issues commands.
- A single module with no sub-modules: one FSM, one window down-counter, one clear counter, and one 64-bit snapshot register.

## Test plan
- Reset, then START; after 10 cycles STOP → `enable_ticks` high for exactly 10 cycles, state RUN→IDLE, no `window_done`.
- WINDOW with arg 5 from IDLE, with `data_tick` driven as a free-running count → `enable_ticks` high for exactly 5 cycles; `window_done` and `snap_valid` pulse together; `snap_data` equals `data_tick` at the expiry edge.
- With `CLEAR_CYCLES`=2: CLEAR during RUN → `enable_ticks` 0 and `reset_ticks` high for 2 cycles; `cmd_ready` low for those 2 cycles; `cmd_valid` held high during CLR is accepted only afterward; final state IDLE.
- SNAP with `data_tick`=0x0000_0001_FFFF_FFFF → the next cycle gives `snap_data`=0x0000_0001_FFFF_FFFF and a single `snap_valid` pulse; state unchanged.
- WINDOW with arg 0 → `window_done` pulses next cycle, `enable_ticks` never rises. Opcode 6 → `cmd_err` pulses, state unchanged.
- WINDOW with arg 100, then assert `reset` at cycle 40 → all outputs go to reset values asynchronously, with no `window_done`.

Source files
------------

// File: rtl/tick_pkg.sv
// Shared definitions for the tick counter command path: opcodes issued by the
// register block and the sequencer state encoding reported back for status.
package tick_pkg;

  // Command opcodes; values 5..7 are illegal and flagged by the sequencer.
  localparam logic [2:0] OP_SNAP   = 3'd0;
  localparam logic [2:0] OP_START  = 3'd1;
  localparam logic [2:0] OP_STOP   = 3'd2;
  localparam logic [2:0] OP_CLEAR  = 3'd3;
  localparam logic [2:0] OP_WINDOW = 3'd4;

  // Sequencer state, readable by software.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WIN  = 2'd2,
    ST_CLR  = 2'd3
  } tick_state_e;

  // True for opcodes that end or replace an active window.
  function automatic logic op_preempts_window(input logic [2:0] op);
    return (op == OP_STOP) || (op == OP_CLEAR) || (op == OP_WINDOW);
  endfunction

endpackage

// File: rtl/tick_seq_ctrl.sv
// Command sequencer for the 64-bit tick counter: turns single commands into
// cycle-exact enable/clear sequencing and captures atomic tick snapshots.
module tick_seq_ctrl
  import tick_pkg::*;
#(
  parameter int CLEAR_CYCLES = 2,
  parameter int WIN_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [WIN_WIDTH-1:0] cmd_arg,
  input  logic [63:0]          data_tick,
  output logic                 enable_ticks,
  output logic                 reset_ticks,
  output logic [63:0]          snap_data,
  output logic                 snap_valid,
  output logic                 window_done,
  output logic                 cmd_err,
  output logic [1:0]           state
);

  localparam logic [WIN_WIDTH-1:0] WIN_ONE  = {{(WIN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]           CLR_LOAD = 4'(CLEAR_CYCLES);
  localparam logic [3:0]           CLR_ONE  = 4'd1;

  tick_state_e          state_r;
  logic [WIN_WIDTH-1:0] win_cnt_r;
  logic [3:0]           clr_cnt_r;
  logic                 enable_ticks_r;
  logic                 reset_ticks_r;
  logic [63:0]          snap_data_r;
  logic                 snap_valid_r;
  logic                 window_done_r;
  logic                 cmd_err_r;

  logic                 cmd_ready_s;
  logic                 accept_s;
  logic                 expire_s;
  logic                 capture_s;

  // Handshake and window-expiry decode; a preempting command cancels expiry.
  always_comb begin
    cmd_ready_s = (state_r != ST_CLR);
    accept_s    = cmd_valid && cmd_ready_s;
    if ((state_r == ST_WIN) && (win_cnt_r == WIN_ONE)) begin
      expire_s = !(accept_s && op_preempts_window(cmd_op));
    end else begin
      expire_s = 1'b0;
    end
    // A SNAP landing on the expiry edge merges into the single expiry capture.
    capture_s = expire_s || (accept_s && (cmd_op == OP_SNAP));
  end

  // Sequencer FSM with registered enable/clear outputs, counters and pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      win_cnt_r      <= '0;
      clr_cnt_r      <= 4'd0;
      enable_ticks_r <= 1'b0;
      reset_ticks_r  <= 1'b0;
      snap_data_r    <= 64'd0;
      snap_valid_r   <= 1'b0;
      window_done_r  <= 1'b0;
      cmd_err_r      <= 1'b0;
    end else begin
      snap_valid_r  <= capture_s;
      window_done_r <= 1'b0;
      cmd_err_r     <= 1'b0;
      if (capture_s) begin
        snap_data_r <= data_tick;
      end

      case (state_r)
        ST_CLR: begin
          if (clr_cnt_r <= CLR_ONE) begin
            state_r       <= ST_IDLE;
            reset_ticks_r <= 1'b0;
            clr_cnt_r     <= 4'd0;
          end else begin
            clr_cnt_r <= clr_cnt_r - 4'd1;
          end
        end

        ST_IDLE, ST_RUN, ST_WIN: begin
          // Window progression first; an accepted command below overrides it.
          if (expire_s) begin
            state_r        <= ST_IDLE;
            enable_ticks_r <= 1'b0;
            window_done_r  <= 1'b1;
            win_cnt_r      <= '0;
          end else if (state_r == ST_WIN) begin
            win_cnt_r <= win_cnt_r - WIN_ONE;
          end

          if (accept_s) begin
            case (cmd_op)
              OP_SNAP: begin
                // capture handled above
              end
              OP_START: begin
                if (state_r == ST_IDLE) begin
                  state_r        <= ST_RUN;
                  enable_ticks_r <= 1'b1;
                end
              end
              OP_STOP: begin
                state_r        <= ST_IDLE;
                enable_ticks_r <= 1'b0;
                win_cnt_r      <= '0;
              end
              OP_CLEAR: begin
                state_r        <= ST_CLR;
                enable_ticks_r <= 1'b0;
                reset_ticks_r  <= 1'b1;
                clr_cnt_r      <= CLR_LOAD;
                win_cnt_r      <= '0;
              end
              OP_WINDOW: begin
                if (cmd_arg == '0) begin
                  state_r        <= ST_IDLE;
                  enable_ticks_r <= 1'b0;
                  window_done_r  <= 1'b1;
                  win_cnt_r      <= '0;
                end else begin
                  state_r        <= ST_WIN;
                  enable_ticks_r <= 1'b1;
                  win_cnt_r      <= cmd_arg;
                end
              end
              default: begin
                cmd_err_r <= 1'b1;
              end
            endcase
          end
        end

        default: begin
          state_r        <= ST_IDLE;
          enable_ticks_r <= 1'b0;
          reset_ticks_r  <= 1'b0;
          win_cnt_r      <= '0;
          clr_cnt_r      <= 4'd0;
        end
      endcase
    end
  end

  assign cmd_ready    = cmd_ready_s;
  assign enable_ticks = enable_ticks_r;
  assign reset_ticks  = reset_ticks_r;
  assign snap_data    = snap_data_r;
  assign snap_valid   = snap_valid_r;
  assign window_done  = window_done_r;
  assign cmd_err      = cmd_err_r;
  assign state        = state_r;

endmodule

// File: tb/tb_tick_seq_ctrl.sv
// Bench for tick_seq_ctrl: directed scenarios plus random commands, all
// compared each cycle against a behavioural model of the command rules.
module tb_tick_seq_ctrl;

  localparam int CLEAR_CYCLES = 2;
  localparam int WIN_WIDTH    = 32;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [2:0]           cmd_op;
  logic [WIN_WIDTH-1:0] cmd_arg;
  logic [63:0]          data_tick;
  logic                 enable_ticks;
  logic                 reset_ticks;
  logic [63:0]          snap_data;
  logic                 snap_valid;
  logic                 window_done;
  logic                 cmd_err;
  logic [1:0]           state;

  tick_seq_ctrl #(.CLEAR_CYCLES(CLEAR_CYCLES), .WIN_WIDTH(WIN_WIDTH)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .data_tick(data_tick),
    .enable_ticks(enable_ticks), .reset_ticks(reset_ticks),
    .snap_data(snap_data), .snap_valid(snap_valid), .window_done(window_done),
    .cmd_err(cmd_err), .state(state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  // Model: free-running flag, remaining enabled window cycles, remaining clear cycles.
  bit          m_run;
  longint      m_win;
  int          m_clr;
  logic [63:0] m_snap;
  bit          m_sv, m_done, m_err;
  logic [63:0] free_cnt = 64'd0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_state();
    if (m_clr > 0)      return 2'd3;
    else if (m_win > 0) return 2'd2;
    else if (m_run)     return 2'd1;
    else                return 2'd0;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_win = 0; m_clr = 0; m_snap = 64'd0;
    m_sv = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endtask

  // Apply the command rules for one rising edge using the inputs presented.
  task automatic model_edge();
    bit acc, was_win, was_idle, tick_win;
    acc      = cmd_valid && (m_clr == 0);
    was_win  = (m_win > 0);
    was_idle = (m_clr == 0) && !was_win && !m_run;
    m_sv = 1'b0; m_done = 1'b0; m_err = 1'b0;
    if (m_clr > 0) m_clr--;
    tick_win = was_win && !(acc && (cmd_op == 3'd2 || cmd_op == 3'd3 || cmd_op == 3'd4));
    if (tick_win) begin
      m_win--;
      if (m_win == 0) begin
        m_done = 1'b1;
        m_sv   = 1'b1;
        m_snap = data_tick;
      end
    end
    if (acc) begin
      case (cmd_op)
        3'd0: begin m_sv = 1'b1; m_snap = data_tick; end
        3'd1: if (was_idle) m_run = 1'b1;
        3'd2: begin m_run = 1'b0; m_win = 0; end
        3'd3: begin m_run = 1'b0; m_win = 0; m_clr = CLEAR_CYCLES; end
        3'd4: begin
          m_run = 1'b0;
          m_win = longint'(cmd_arg);
          if (cmd_arg == 32'd0) m_done = 1'b1;
        end
        default: m_err = 1'b1;
      endcase
    end
  endtask

  task automatic check_outputs();
    check_val("enable_ticks", {63'd0, enable_ticks}, {63'd0, m_run || (m_win > 0)});
    check_val("reset_ticks",  {63'd0, reset_ticks},  {63'd0, m_clr > 0});
    check_val("cmd_ready",    {63'd0, cmd_ready},    {63'd0, m_clr == 0});
    check_val("state",        {62'd0, state},        {62'd0, m_state()});
    check_val("snap_valid",   {63'd0, snap_valid},   {63'd0, m_sv});
    check_val("window_done",  {63'd0, window_done},  {63'd0, m_done});
    check_val("cmd_err",      {63'd0, cmd_err},      {63'd0, m_err});
    check_val("snap_data",    snap_data,             m_snap);
  endtask

  // One cycle: present inputs, update model at the edge, compare at the falling edge.
  task automatic step(input bit v, input logic [2:0] op, input logic [31:0] arg,
                      input logic [63:0] dat);
    cmd_valid = v; cmd_op = op; cmd_arg = arg; data_tick = dat;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_step();
    free_cnt = free_cnt + 64'd1;
    step(1'b0, 3'd0, 32'd0, free_cnt);
  endtask

  int en_cnt, rst_cnt, done_cnt;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = '0; data_tick = 64'd0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_outputs();

    // START, then STOP ten cycles later.
    en_cnt = 0; done_cnt = 0;
    step(1'b1, 3'd1, 32'd0, free_cnt);
    en_cnt += int'(enable_ticks);
    for (int i = 0; i < 9; i++) begin
      idle_step();
      en_cnt += int'(enable_ticks); done_cnt += int'(window_done);
    end
    step(1'b1, 3'd2, 32'd0, free_cnt);
    en_cnt += int'(enable_ticks); done_cnt += int'(window_done);
    check_val("start_stop_en_cycles", 64'(en_cnt), 64'd10);
    check_val("start_stop_no_done", 64'(done_cnt), 64'd0);

    // WINDOW 5 with free-running data_tick.
    en_cnt = 0;
    free_cnt = free_cnt + 64'd1;
    step(1'b1, 3'd4, 32'd5, free_cnt);
    en_cnt += int'(enable_ticks);
    for (int i = 0; i < 6; i++) begin
      idle_step();
      en_cnt += int'(enable_ticks);
      if (window_done) begin
        check_val("win5_snap_together", {63'd0, snap_valid}, 64'd1);
        check_val("win5_snap_data", snap_data, free_cnt);
      end
    end
    check_val("win5_en_cycles", 64'(en_cnt), 64'd5);

    // CLEAR during RUN, command held valid through the clear.
    step(1'b1, 3'd1, 32'd0, free_cnt);
    idle_step();
    rst_cnt = 0;
    step(1'b1, 3'd3, 32'd0, free_cnt);
    rst_cnt += int'(reset_ticks);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 3'd1, 32'd0, free_cnt);
      rst_cnt += int'(reset_ticks);
    end
    check_val("clear_cycles", 64'(rst_cnt), 64'(CLEAR_CYCLES));
    step(1'b1, 3'd2, 32'd0, free_cnt);

    // SNAP of a value straddling the 32-bit boundary.
    step(1'b1, 3'd0, 32'd0, 64'h0000_0001_FFFF_FFFF);
    check_val("snap_boundary", snap_data, 64'h0000_0001_FFFF_FFFF);
    idle_step();

    // WINDOW 0 and an illegal opcode.
    step(1'b1, 3'd4, 32'd0, free_cnt);
    idle_step();
    step(1'b1, 3'd6, 32'd0, free_cnt);
    idle_step();

    // SNAP on the expiry edge: a single capture.
    step(1'b1, 3'd4, 32'd3, free_cnt);
    idle_step();
    idle_step();
    step(1'b1, 3'd0, 32'd0, 64'hDEAD_BEEF_0000_0042);
    check_val("snap_on_expiry", snap_data, 64'hDEAD_BEEF_0000_0042);
    idle_step();

    // WINDOW 100, then asynchronous reset in cycle 40.
    step(1'b1, 3'd4, 32'd100, free_cnt);
    for (int i = 0; i < 39; i++) idle_step();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      idle_step();
      done_cnt += int'(window_done);
    end
    check_val("reset_no_done", 64'(done_cnt), 64'd0);

    // Random command traffic.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] arg;
      logic [2:0]  op;
      bit          v;
      v   = ($urandom_range(0, 2) != 0);
      op  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      arg = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 12));
      step(v, op, arg, {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
